// File: rtl/serial_byte_deserializer.sv
// Serial-in/parallel-out word assembler with valid/ready output handshake.
// Optional even-parity check enabled by defining SERIAL_BYTE_DESER_PARITY_EN.
module serial_byte_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    input  logic             clear,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic             take;

    assign sin_ready = (state != HOLD);
    assign take      = sin_valid & sin_ready;

    always_comb begin
        sreg_nxt = '0;
        if (MSB_FIRST)
            sreg_nxt = {sreg[WIDTH-2:0], sin};
        else
            sreg_nxt = {sin, sreg[WIDTH-1:1]};
    end

`ifndef SERIAL_BYTE_DESER_PARITY_EN
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            sreg      <= '0;
            par_out   <= '0;
            par_valid <= 1'b0;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else if (clear) begin
            state     <= IDLE;
            count     <= '0;
            sreg      <= '0;
            par_valid <= 1'b0;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            case (state)
                // IDLE and SHIFT differ only in count, which is already 0 in IDLE
                IDLE, SHIFT: begin
                    if (take) begin
                        if (count == LAST) begin
                            count <= '0;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
                            sreg  <= sreg_nxt;
                            state <= PARITY;
`else
                            sreg      <= '0;
                            par_out   <= sreg_nxt;
                            par_valid <= 1'b1;
                            state     <= HOLD;
`endif
                        end else begin
                            sreg  <= sreg_nxt;
                            count <= count + 1'b1;
                            state <= SHIFT;
                        end
                    end
                end
`ifdef SERIAL_BYTE_DESER_PARITY_EN
                PARITY: begin
                    if (take) begin
                        par_out   <= sreg;
                        par_err   <= (^sreg) ^ sin;
                        par_valid <= 1'b1;
                        sreg      <= '0;
                        state     <= HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (par_ready) begin
                        par_valid <= 1'b0;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
                        par_err   <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Bench for serial_byte_deserializer: constant vector table, directed corner
// sequences and randomized traffic checked against a bit-queue reference model.
module tb_serial_byte_deserializer;

    localparam int W   = 8;
    localparam bit MSB = 1'b0;
`ifdef SERIAL_BYTE_DESER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sin_ready;
    logic         clear = 1'b0;
    logic [W-1:0] par_out;
    logic         par_valid;
    logic         par_ready = 1'b0;
    logic         par_err;

    int nvec = 0;
    int nerr = 0;

    // Reference model: received bits kept in a queue until a full word exists
    bit           m_bits[$];
    logic [W-1:0] m_out = '0;
    bit           m_valid = 1'b0;
    bit           m_err = 1'b0;

    serial_byte_deserializer #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sin_ready (sin_ready),
        .clear     (clear),
        .par_out   (par_out),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         s, sv, cl, pr;
        logic [W-1:0] out;
        logic         v, rdy;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        bit p;
        if (!rst_n) begin
            model_reset();
        end else if (clear) begin
            m_bits.delete();
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else if (m_valid) begin
            if (par_ready) begin
                m_valid = 1'b0;
                m_err   = 1'b0;
            end
        end else if (sin_valid) begin
            m_bits.push_back(sin);
            if (m_bits.size() == NB) begin
                m_out = '0;
                for (int i = 0; i < W; i++)
                    m_out[MSB ? W - 1 - i : i] = m_bits[i];
                p = 1'b0;
                foreach (m_bits[i]) p ^= m_bits[i];
`ifdef SERIAL_BYTE_DESER_PARITY_EN
                m_err = p;
`else
                m_err = 1'b0;
`endif
                m_valid = 1'b1;
                m_bits.delete();
            end
        end
    endtask

    task automatic cycle(input logic s, input logic sv, input logic cl, input logic pr);
        sin = s; sin_valid = sv; clear = cl; par_ready = pr;
        @(posedge clk);
        model_step();
        #1;
        chk("par_out",   par_out,   m_out);
        chk("par_valid", par_valid, m_valid);
        chk("sin_ready", sin_ready, !m_valid);
        chk("par_err",   par_err,   m_err);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit gap, input logic pr);
        for (int i = 0; i < W; i++) begin
            if (gap) cycle(1'b1, 1'b0, 1'b0, pr);
            cycle(w[MSB ? W - 1 - i : i], 1'b1, 1'b0, pr);
        end
`ifdef SERIAL_BYTE_DESER_PARITY_EN
        cycle(^w, 1'b1, 1'b0, pr);
`endif
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out",   par_out,   '0);
        chk("rst_valid", par_valid, 1'b0);
        chk("rst_err",   par_err,   1'b0);
        chk("rst_ready", sin_ready, 1'b1);
        for (int i = 0; i < n; i++) begin
            sin = 1'($urandom); sin_valid = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_hold_out",   par_out,   '0);
            chk("rst_hold_valid", par_valid, 1'b0);
            chk("rst_hold_ready", sin_ready, 1'b1);
        end
        sin_valid = 1'b0;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t tbl[$];

        // Reset with random serial activity
        @(posedge clk);
        #1;
        do_reset(4);

`ifndef SERIAL_BYTE_DESER_PARITY_EN
        // 8'h4D LSB-first back-to-back, then abort after 4 bits and send all ones
        tbl.push_back('{1, 1, 0, 1, 8'h00, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 8'h00, 0, 1});
        tbl.push_back('{1, 1, 0, 1, 8'h00, 0, 1});
        tbl.push_back('{1, 1, 0, 1, 8'h00, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 8'h00, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 8'h00, 0, 1});
        tbl.push_back('{1, 1, 0, 1, 8'h00, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 8'h4D, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 8'h4D, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 8'h4D, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 8'h4D, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 8'h4D, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 8'h4D, 0, 1});
        tbl.push_back('{1, 1, 1, 0, 8'h4D, 0, 1});
        for (int i = 0; i < 7; i++)
            tbl.push_back('{1, 1, 0, 0, 8'h4D, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 8'hFF, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 8'hFF, 0, 1});

        foreach (tbl[i]) begin
            sin = tbl[i].s; sin_valid = tbl[i].sv; clear = tbl[i].cl; par_ready = tbl[i].pr;
            @(posedge clk);
            model_step();
            #1;
            chk("tbl_out",   par_out,   tbl[i].out);
            chk("tbl_valid", par_valid, tbl[i].v);
            chk("tbl_ready", sin_ready, tbl[i].rdy);
        end
`endif

        // Gapped word, consumer stalls while extra bits are offered
        send_word(8'h4D, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'($urandom), 1'b1, 1'b0, 1'b0);
            chk("stall_out",   par_out,   8'h4D);
            chk("stall_ready", sin_ready, 1'b0);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        chk("release_valid", par_valid, 1'b0);
        chk("release_ready", sin_ready, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a word
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset(2);
        send_word(8'h81, 1'b0, 1'b0);
        chk("post_rst_out",   par_out,   8'h81);
        chk("post_rst_valid", par_valid, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Clear while a word is pending drops it but keeps par_out
        send_word(8'h3C, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_hold_valid", par_valid, 1'b0);
        chk("clr_hold_out",   par_out,   8'h3C);

`ifdef SERIAL_BYTE_DESER_PARITY_EN
        for (int i = 0; i < W; i++) cycle(1'(8'h4D >> i), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("parity_bad", par_err, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("parity_clr", par_err, 1'b0);
        for (int i = 0; i < W; i++) cycle(1'(8'h4D >> i), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("parity_ok", par_err, 1'b0);
        chk("parity_out", par_out, 8'h4D);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
`else
        // Ninth bit is the start of the next word
        send_word(8'h4D, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ninth_valid", par_valid, 1'b0);
        for (int i = 0; i < W - 1; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ninth_out",   par_out,   8'h01);
        chk("ninth_wvalid", par_valid, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3),
                  1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
